// File: rtl/cpu_clk_gen.sv
// CPU clock generator: fast/slow free-running, debounced single-step and pause modes.
// Optional single-step hardware is enabled with the CLKGEN_STEP_EN macro.
module cpu_clk_gen #(
    parameter int CNT_W    = 32,
    parameter int FAST_TAP = 2,
    parameter int SLOW_TAP = 25,
    parameter int DB_W     = 20,
    parameter int DB_CYC   = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    output logic             Clk_CPU,
    output logic             cpu_rise,
    output logic [1:0]       cur_mode,
    output logic [CNT_W-1:0] cpu_cycles
);

    typedef enum logic [1:0] {
        MODE_FAST  = 2'b00,
        MODE_SLOW  = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_PAUSE = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'((64'd1 << FAST_TAP) - 64'd1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'((64'd1 << SLOW_TAP) - 64'd1);

    mode_e            mode_q, mode_d, cur_q, cur_d;
    logic             clk_q, clk_d, rise_q, rise_d;
    logic [CNT_W-1:0] ph_q, ph_d, cyc_q, cyc_d;
    logic             step_pulse_s;

`ifdef CLKGEN_STEP_EN
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

    logic            sync1_q, sync2_q, stable_q, stable_d, pulse_q, pulse_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Debouncer: accept a new level only after DB_CYC consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        pulse_d  = 1'b0;
        if (sync2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = sync2_q;
            db_cnt_d = '0;
            pulse_d  = sync2_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= step_btn;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign step_pulse_s = pulse_q;

    // Requested mode passes through unchanged.
    always_comb begin
        mode_d = mode_e'(mode);
    end
`else
    logic unused_step_btn_s;

    assign unused_step_btn_s = step_btn;
    assign step_pulse_s      = 1'b0;

    // Without step hardware, a STEP request is reported and treated as PAUSE.
    always_comb begin
        if (mode == 2'b10) begin
            mode_d = MODE_PAUSE;
        end else begin
            mode_d = mode_e'(mode);
        end
    end
`endif

    // Clock phase / mode-switch next state; switches only while low so no runt pulses.
    always_comb begin
        clk_d  = clk_q;
        rise_d = 1'b0;
        ph_d   = ph_q;
        cyc_d  = cyc_q;
        cur_d  = cur_q;
        if (!clk_q && (mode_q != cur_q)) begin
            cur_d = mode_q;
            ph_d  = '0;
        end else begin
            case (cur_q)
                MODE_FAST, MODE_SLOW: begin
                    if (ph_q == ((cur_q == MODE_FAST) ? FAST_LAST : SLOW_LAST)) begin
                        ph_d   = '0;
                        clk_d  = ~clk_q;
                        rise_d = ~clk_q;
                        if (!clk_q) begin
                            cyc_d = cyc_q + ONE_C;
                        end else begin
                            cyc_d = cyc_q;
                        end
                    end else begin
                        ph_d = ph_q + ONE_C;
                    end
                end
                MODE_STEP: begin
                    if (clk_q) begin
                        if (ph_q == FAST_LAST) begin
                            ph_d  = '0;
                            clk_d = 1'b0;
                        end else begin
                            ph_d = ph_q + ONE_C;
                        end
                    end else if (step_pulse_s) begin
                        clk_d  = 1'b1;
                        rise_d = 1'b1;
                        ph_d   = '0;
                        cyc_d  = cyc_q + ONE_C;
                    end else begin
                        ph_d = '0;
                    end
                end
                MODE_PAUSE: begin
                    clk_d = 1'b0;
                    ph_d  = '0;
                end
                default: begin
                    clk_d = 1'b0;
                    ph_d  = '0;
                end
            endcase
        end
    end

    // Clock generator state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_FAST;
            cur_q  <= MODE_FAST;
            clk_q  <= 1'b0;
            rise_q <= 1'b0;
            ph_q   <= '0;
            cyc_q  <= '0;
        end else begin
            mode_q <= mode_d;
            cur_q  <= cur_d;
            clk_q  <= clk_d;
            rise_q <= rise_d;
            ph_q   <= ph_d;
            cyc_q  <= cyc_d;
        end
    end

    assign Clk_CPU    = clk_q;
    assign cpu_rise   = rise_q;
    assign cur_mode   = cur_q;
    assign cpu_cycles = cyc_q;

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Directed bench for cpu_clk_gen: instance A is the main model, B checks counter wrap,
// C (long step pulse, short debounce) checks that presses during a high phase are dropped.
module tb_cpu_clk_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       step_btn;

    logic       a_clk_s, a_rise_s, b_clk_s, b_rise_s, c_clk_s, c_rise_s;
    logic [1:0] a_cur_s, b_cur_s, c_cur_s;
    logic [7:0] a_cyc_s, c_cyc_s;
    logic [3:0] b_cyc_s;

    int checks   = 0;
    int failures = 0;
    int n;
    logic hi_seen;

    always #5 clk = ~clk;

    cpu_clk_gen #(.CNT_W(8), .FAST_TAP(2), .SLOW_TAP(4), .DB_W(20), .DB_CYC(4)) u_a (
        .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn),
        .Clk_CPU(a_clk_s), .cpu_rise(a_rise_s), .cur_mode(a_cur_s), .cpu_cycles(a_cyc_s));

    cpu_clk_gen #(.CNT_W(4), .FAST_TAP(2), .SLOW_TAP(3), .DB_W(20), .DB_CYC(4)) u_b (
        .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn),
        .Clk_CPU(b_clk_s), .cpu_rise(b_rise_s), .cur_mode(b_cur_s), .cpu_cycles(b_cyc_s));

    cpu_clk_gen #(.CNT_W(8), .FAST_TAP(4), .SLOW_TAP(5), .DB_W(20), .DB_CYC(2)) u_c (
        .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn),
        .Clk_CPU(c_clk_s), .cpu_rise(c_rise_s), .cur_mode(c_cur_s), .cpu_cycles(c_cyc_s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count negedges until instance A's clock reaches level v (bounded).
    task automatic wait_lvl(input logic v, input int budget, output int cnt);
        cnt = 0;
        while ((a_clk_s !== v) && (cnt < budget)) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; step_btn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_clk", {31'd0, a_clk_s}, 32'd0);
        chk("rst_rise", {31'd0, a_rise_s}, 32'd0);
        chk("rst_cur", {30'd0, a_cur_s}, 32'd0);
        chk("rst_cyc", {24'd0, a_cyc_s}, 32'd0);
        rst = 1'b0;

        // Test 1: FAST timing
        wait_lvl(1'b1, 20, n);  chk("fast_first_rise", n, 32'd4);
        chk("fast_rise_pulse", {31'd0, a_rise_s}, 32'd1);
        chk("fast_cyc1", {24'd0, a_cyc_s}, 32'd1);
        @(negedge clk);
        chk("fast_rise_1cyc", {31'd0, a_rise_s}, 32'd0);
        wait_lvl(1'b0, 20, n);  chk("fast_high_rest", n, 32'd3);
        wait_lvl(1'b1, 20, n);  chk("fast_low", n, 32'd4);
        chk("fast_cyc2", {24'd0, a_cyc_s}, 32'd2);

        // Test 2: switch to SLOW while high
        mode = 2'b01;
        wait_lvl(1'b0, 20, n);  chk("sw_high_full", n, 32'd4);
        chk("sw_cur_hold", {30'd0, a_cur_s}, 32'd0);
        @(negedge clk);
        chk("sw_cur_slow", {30'd0, a_cur_s}, 32'd1);
        wait_lvl(1'b1, 40, n);  chk("slow_low", n, 32'd16);
        wait_lvl(1'b0, 40, n);  chk("slow_high", n, 32'd16);
        chk("slow_cyc", {24'd0, a_cyc_s}, 32'd3);

        // Test 4: PAUSE for 100 cycles, then back to FAST
        mode = 2'b11;
        hi_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_clk_s !== 1'b0) hi_seen = 1'b1;
        end
        chk("pause_low", {31'd0, hi_seen}, 32'd0);
        chk("pause_cyc", {24'd0, a_cyc_s}, 32'd3);
        chk("pause_cur", {30'd0, a_cur_s}, 32'd3);
        mode = 2'b00;
        @(negedge clk);
        chk("unpause_lat", {30'd0, a_cur_s}, 32'd3);
        @(negedge clk);
        chk("unpause_cur", {30'd0, a_cur_s}, 32'd0);
        wait_lvl(1'b1, 20, n);  chk("unpause_rise", n, 32'd4);
        chk("unpause_cyc", {24'd0, a_cyc_s}, 32'd4);

        // Test 5: reset mid-high in SLOW
        mode = 2'b01;
        wait_lvl(1'b0, 20, n);  chk("t5_high", n, 32'd4);
        @(negedge clk);
        wait_lvl(1'b1, 40, n);  chk("t5_low", n, 32'd16);
        repeat (5) @(negedge clk);
        rst = 1'b1; mode = 2'b00;
        @(negedge clk);
        chk("midrst_clk", {31'd0, a_clk_s}, 32'd0);
        chk("midrst_cur", {30'd0, a_cur_s}, 32'd0);
        chk("midrst_cyc", {24'd0, a_cyc_s}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Test 6: 4-bit counter wraps after 16 rises
        repeat (116) @(negedge clk);
        chk("wrap_b15", {28'd0, b_cyc_s}, 32'd15);
        chk("wrap_b15_rise", {31'd0, b_rise_s}, 32'd1);
        repeat (8) @(negedge clk);
        chk("wrap_b0", {28'd0, b_cyc_s}, 32'd0);
        chk("wrap_b_clk", {31'd0, b_clk_s}, 32'd1);
        chk("wrap_b_cur", {30'd0, b_cur_s}, 32'd0);
        chk("wrap_a16", {24'd0, a_cyc_s}, 32'd16);
        chk("wrap_c4", {24'd0, c_cyc_s}, 32'd4);

        mode = 2'b10;
        repeat (40) @(negedge clk);
`ifdef CLKGEN_STEP_EN
        chk("step_cur_a", {30'd0, a_cur_s}, 32'd2);
        chk("step_cur_c", {30'd0, c_cur_s}, 32'd2);
        chk("step_rest", {31'd0, a_clk_s}, 32'd0);
        // Test 3: one clean 12-cycle press
        step_btn = 1'b1;
        wait_lvl(1'b1, 30, n);  chk("step_lat", n, 32'd7);
        wait_lvl(1'b0, 30, n);  chk("step_width", n, 32'd4);
        chk("step_cyc", {24'd0, a_cyc_s}, 32'd17);
        @(negedge clk);
        step_btn = 1'b0;
        repeat (20) @(negedge clk);
        chk("step_release", {24'd0, a_cyc_s}, 32'd17);
        // Glitches of 1..3 cycles
        for (int g = 1; g <= 3; g++) begin
            step_btn = 1'b1;
            repeat (g) @(negedge clk);
            step_btn = 1'b0;
            repeat (20) @(negedge clk);
        end
        chk("glitch_a", {24'd0, a_cyc_s}, 32'd17);
        chk("glitch_c", {24'd0, c_cyc_s}, 32'd7);
        // Second press during the high phase of C is dropped
        step_btn = 1'b1; repeat (6) @(negedge clk);
        step_btn = 1'b0; repeat (6) @(negedge clk);
        step_btn = 1'b1; repeat (6) @(negedge clk);
        step_btn = 1'b0; repeat (30) @(negedge clk);
        chk("two_press_a", {24'd0, a_cyc_s}, 32'd19);
        chk("drop_press_c", {24'd0, c_cyc_s}, 32'd8);
        chk("drop_c_low", {31'd0, c_clk_s}, 32'd0);
        chk("drop_a_low", {31'd0, a_clk_s}, 32'd0);
`else
        chk("nostep_cur_a", {30'd0, a_cur_s}, 32'd3);
        chk("nostep_cur_c", {30'd0, c_cur_s}, 32'd3);
        hi_seen = 1'b0;
        for (int p = 0; p < 3; p++) begin
            step_btn = 1'b1;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if ((a_clk_s !== 1'b0) || (c_clk_s !== 1'b0)) hi_seen = 1'b1;
            end
            step_btn = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if ((a_clk_s !== 1'b0) || (c_clk_s !== 1'b0)) hi_seen = 1'b1;
            end
        end
        chk("nostep_low", {31'd0, hi_seen}, 32'd0);
        chk("nostep_cyc_a", {24'd0, a_cyc_s}, 32'd16);
        chk("nostep_cyc_c", {24'd0, c_cyc_s}, 32'd4);
        chk("nostep_rise", {31'd0, a_rise_s | c_rise_s}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
